ram_bist_master: RTL and testbench

//  Bus initiator for the data-RAM port (addr/sel/ld/wdata/rdata/clr). It drives the same

---
 rtl/bist_pkg.sv | 18 +
 rtl/bist_expect_pipe.sv | 46 ++++
 rtl/ram_bist_master.sv | 159 +++++++++++++++
 tb/tb_ram_bist_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and I/O map constants for the RAM self-test master.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD0,
    WRP,
    RDP,
    WRN,
    RDN,
    DRAIN
  } bist_state_e;

  localparam int unsigned MMIO_BTN_ADDR = 0;
  localparam int unsigned MMIO_HEX_ADDR = 1;

endpackage

// File: rtl/bist_expect_pipe.sv
// Valid-tagged shift pipe carrying {addr, expect} alongside outstanding RAM loads.
module bist_expect_pipe #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_exp,
  output logic              tail_vld,
  output logic [ADDR_W-1:0] tail_addr,
  output logic [DATA_W-1:0] tail_exp,
  output logic              empty
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_q  [RD_LAT];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld[0]    <= push;
      addr_q[0] <= push_addr;
      exp_q[0]  <= push_exp;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld[i]    <= vld[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  assign tail_vld  = vld[RD_LAT-1];
  assign tail_addr = addr_q[RD_LAT-1];
  assign tail_exp  = exp_q[RD_LAT-1];
  assign empty     = ~|vld;

endmodule

// File: rtl/ram_bist_master.sv
// RAM self-test bus initiator: clear, check zero, write/read pattern, write/read inverse.
module ram_bist_master
  import bist_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       BASE_ADDR = ((MMIO_BTN_ADDR > MMIO_HEX_ADDR) ? MMIO_BTN_ADDR : MMIO_HEX_ADDR) + 1,
  parameter int unsigned       DEPTH     = 62,
  parameter logic [DATA_W-1:0] SEED      = 16'hA5C3,
  parameter int unsigned       RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_sel,
  output logic              mem_ld,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_clr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(BASE_ADDR + DEPTH - 1);

  if ((64'(BASE_ADDR) + 64'(DEPTH)) > (64'd1 << ADDR_W)) begin : g_range_chk
    $error("ram_bist_master: BASE_ADDR+DEPTH exceeds the address space");
  end
  if (DEPTH == 0 || RD_LAT == 0) begin : g_size_chk
    $error("ram_bist_master: DEPTH and RD_LAT must be nonzero");
  end

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] addr);
    return DATA_W'(addr) ^ SEED;
  endfunction

  bist_state_e       state, state_n;
  logic [ADDR_W-1:0] a, a_n, addr_n;
  logic [DATA_W-1:0] wdata_n, push_exp;
  logic              sel_n, ld_n, clr_n, push, last_a;
  logic              tail_vld, pipe_empty;
  logic [ADDR_W-1:0] tail_addr;
  logic [DATA_W-1:0] tail_exp;

  assign last_a = (a == LAST_A);

  always_comb begin
    state_n  = state;
    a_n      = a;
    sel_n    = 1'b0;
    ld_n     = 1'b0;
    clr_n    = 1'b0;
    addr_n   = '0;
    wdata_n  = '0;
    push     = 1'b0;
    push_exp = '0;
    case (state)
      IDLE:  if (start) state_n = CLR;
      CLR: begin
        clr_n   = 1'b1;
        a_n     = FIRST_A;
        state_n = RD0;
      end
      RD0, WRP, RDP, WRN, RDN: begin
        sel_n  = 1'b1;
        addr_n = a;
        a_n    = last_a ? FIRST_A : a + 1'b1;
        case (state)
          RD0: begin ld_n = 1'b1; push = 1'b1; push_exp = '0;      end
          WRP: wdata_n = pat(a);
          RDP: begin ld_n = 1'b1; push = 1'b1; push_exp = pat(a);  end
          WRN: wdata_n = ~pat(a);
          default: begin ld_n = 1'b1; push = 1'b1; push_exp = ~pat(a); end
        endcase
        if (last_a) begin
          case (state)
            RD0:     state_n = WRP;
            WRP:     state_n = RDP;
            RDP:     state_n = WRN;
            WRN:     state_n = RDN;
            default: state_n = DRAIN;
          endcase
        end
      end
      DRAIN: if (pipe_empty) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus pins are registered copies of the combinational request, so the expect
  // pipe entry and the load it tracks leave on the same edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      a         <= '0;
      mem_addr  <= '0;
      mem_sel   <= 1'b0;
      mem_ld    <= 1'b0;
      mem_wdata <= '0;
      mem_clr   <= 1'b0;
    end else begin
      state     <= state_n;
      a         <= a_n;
      mem_addr  <= addr_n;
      mem_sel   <= sel_n;
      mem_ld    <= ld_n;
      mem_wdata <= wdata_n;
      mem_clr   <= clr_n;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (state == IDLE && start) begin
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (tail_vld && (mem_rdata != tail_exp)) begin
        if (err_count != '1) err_count <= err_count + 8'd1;
        if (err_count == '0) first_err_addr <= tail_addr;
      end
      if (state == DRAIN && pipe_empty) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == '0);
      end
    end
  end

  bist_expect_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .res       (res),
    .push      (push),
    .push_addr (a),
    .push_exp  (push_exp),
    .tail_vld  (tail_vld),
    .tail_addr (tail_addr),
    .tail_exp  (tail_exp),
    .empty     (pipe_empty)
  );

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed bench for ram_bist_master against a behavioural RAM with fault modes.
module tb_ram_bist_master;

  logic        clk;
  logic        res;
  logic        start;
  logic [11:0] mem_addr;
  logic        mem_sel, mem_ld, mem_clr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [11:0] first_err_addr;

  logic        sat_start;
  logic [11:0] sat_addr, sat_first;
  logic        sat_sel, sat_ld, sat_clr, sat_busy, sat_done, sat_pass;
  logic [15:0] sat_wdata;
  logic [15:0] sat_rdata;
  logic [7:0]  sat_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          clr_cnt = 0;
  int          addr_bad = 0;
  int          mode  = 0;
  logic [15:0] preset = '0;
  logic        do_preset = 1'b0;
  int          s_cyc = 0;

  ram_bist_master u_dut (
    .clk            (clk),
    .res            (res),
    .start          (start),
    .mem_addr       (mem_addr),
    .mem_sel        (mem_sel),
    .mem_ld         (mem_ld),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_clr        (mem_clr),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  // Deeper instance so that a constant-data responder drives err_count past 255.
  ram_bist_master #(.DEPTH(100)) u_sat (
    .clk            (clk),
    .res            (res),
    .start          (sat_start),
    .mem_addr       (sat_addr),
    .mem_sel        (sat_sel),
    .mem_ld         (sat_ld),
    .mem_wdata      (sat_wdata),
    .mem_rdata      (sat_rdata),
    .mem_clr        (sat_clr),
    .busy           (sat_busy),
    .done           (sat_done),
    .pass           (sat_pass),
    .err_count      (sat_err),
    .first_err_addr (sat_first)
  );

  assign sat_rdata = 16'h1234;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // mode 0 ideal, 1 bit 3 stuck high at addr 10, 2 clr ignored, 3 always 16'h1234
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (do_preset) begin
      for (int i = 0; i < 64; i++) mem[i] <= preset;
    end else if (mem_clr && mode != 2) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_sel && !mem_ld) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
    if (mem_sel && mem_ld) begin
      if (mode == 3)                         mem_rdata <= 16'h1234;
      else if (mode == 1 && mem_addr == 10)  mem_rdata <= mem[mem_addr[5:0]] | 16'h0008;
      else                                   mem_rdata <= mem[mem_addr[5:0]];
    end else begin
      mem_rdata <= '0;
    end
  end

  always @(negedge clk) begin
    if (mem_clr) clr_cnt <= clr_cnt + 1;
    if (mem_sel && mem_addr < 12'd2) addr_bad <= addr_bad + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_mem(input int m, input logic [15:0] v);
    @(negedge clk);
    mode      = m;
    preset    = v;
    do_preset = 1'b1;
    @(negedge clk);
    do_preset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int n = 0; n < 2000; n++) begin
      if (done) begin
        lat = cyc - s_cyc;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: done timeout got none expected done", name);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_addr"},  32'(mem_addr), 0);
    check({tag, " mem_sel"},   32'(mem_sel), 0);
    check({tag, " mem_ld"},    32'(mem_ld), 0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, " mem_clr"},   32'(mem_clr), 0);
    check({tag, " busy"},      32'(busy), 0);
    check({tag, " done"},      32'(done), 0);
    check({tag, " pass"},      32'(pass), 0);
    check({tag, " err_count"}, 32'(err_count), 0);
    check({tag, " first_err"}, 32'(first_err_addr), 0);
  endtask

  typedef struct {
    int          mode;
    logic [15:0] preset;
    int          exp_err;
    int          exp_first;
    int          exp_pass;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, c0, b0, t0;
    vecs[0] = '{mode: 0, preset: 16'hDEAD, exp_err: 0,   exp_first: 0,  exp_pass: 1};
    vecs[1] = '{mode: 1, preset: 16'hBEEF, exp_err: 2,   exp_first: 10, exp_pass: 0};
    vecs[2] = '{mode: 2, preset: 16'hFFFF, exp_err: 62,  exp_first: 2,  exp_pass: 0};
    vecs[3] = '{mode: 3, preset: 16'h0000, exp_err: 186, exp_first: 2,  exp_pass: 0};

    res = 1'b0;
    start = 1'b0;
    sat_start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    res = 1'b1;

    for (int i = 0; i < 4; i++) begin
      set_mem(vecs[i].mode, vecs[i].preset);
      c0 = clr_cnt;
      b0 = addr_bad;
      pulse_start();
      check($sformatf("v%0d busy_after_start", i), 32'(busy), 1);
      wait_done($sformatf("v%0d", i), lat);
      check($sformatf("v%0d latency", i), lat, 314);
      check($sformatf("v%0d err_count", i), 32'(err_count), vecs[i].exp_err);
      check($sformatf("v%0d first_err_addr", i), 32'(first_err_addr), vecs[i].exp_first);
      check($sformatf("v%0d pass", i), 32'(pass), vecs[i].exp_pass);
      check($sformatf("v%0d busy_at_done", i), 32'(busy), 0);
      check($sformatf("v%0d clr_pulses", i), clr_cnt - c0, 1);
      check($sformatf("v%0d io_addr_hits", i), addr_bad - b0, 0);
    end

    // Reset in the middle of the pattern-write phase, then a clean rerun.
    set_mem(0, 16'h5555);
    pulse_start();
    repeat (100) @(negedge clk);
    res = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst_hold");
    res = 1'b1;
    c0 = clr_cnt;
    pulse_start();
    wait_done("rerun", lat);
    check("rerun latency", lat, 314);
    check("rerun pass", 32'(pass), 1);
    check("rerun err_count", 32'(err_count), 0);
    check("rerun clr_pulses", clr_cnt - c0, 1);

    // Second start while busy is ignored.
    set_mem(0, 16'hA0A0);
    c0 = clr_cnt;
    pulse_start();
    t0 = s_cyc;
    repeat (49) @(negedge clk);
    pulse_start();
    s_cyc = t0;
    wait_done("busy_start", lat);
    check("busy_start latency", lat, 314);
    check("busy_start pass", 32'(pass), 1);
    check("busy_start clr_pulses", clr_cnt - c0, 1);

    // Start sampled on the very edge that raises done is ignored.
    pulse_start();
    repeat (313) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("same_edge done", 32'(done), 1);
    check("same_edge busy", 32'(busy), 0);
    @(negedge clk);
    check("same_edge busy_later", 32'(busy), 0);

    // Start while done restarts and clears the result.
    pulse_start();
    check("restart busy", 32'(busy), 1);
    check("restart done", 32'(done), 0);
    check("restart pass", 32'(pass), 0);
    wait_done("restart", lat);
    check("restart latency", lat, 314);
    check("restart pass_end", 32'(pass), 1);

    // Saturation: 3 load phases x 100 words all mismatching.
    @(negedge clk);
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    t0 = cyc;
    lat = -1;
    for (int n = 0; n < 2000; n++) begin
      if (sat_done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check("sat latency", lat, 504);
    check("sat err_count", 32'(sat_err), 32'hFF);
    check("sat first_err_addr", 32'(sat_first), 2);
    check("sat pass", 32'(sat_pass), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
